// File: rtl/life_ctrl_pkg.sv
// Shared constants, PE command codes and FSM state type for the
// Game-of-Life sequencer and its raster counter.
package life_ctrl_pkg;

  localparam int LIFE_N_PX     = 8;
  localparam int LIFE_N_PY     = 8;
  localparam int LIFE_GEN_BITS = 16;

  localparam int N_PX_BITS = (LIFE_N_PX > 1) ? $clog2(LIFE_N_PX) : 1;
  localparam int N_PY_BITS = (LIFE_N_PY > 1) ? $clog2(LIFE_N_PY) : 1;

  localparam int PE_STATE_BITS = 1;
  localparam int PE_CMD_BITS   = 2;

  localparam logic [PE_CMD_BITS-1:0] PE_CMD_NOP  = 2'd0;
  localparam logic [PE_CMD_BITS-1:0] PE_CMD_LOAD = 2'd1;
  localparam logic [PE_CMD_BITS-1:0] PE_CMD_STEP = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STEP   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RD_ADR = 3'd4,
    ST_RD_OUT = 3'd5,
    ST_FIN    = 3'd6
  } seq_state_e;

endpackage

// File: rtl/life_seq_ctrl_raster_cnt.sv
// Raster x/y cell counter (x inner, y outer) shared by pattern load and
// readout; wraps against the explicit array size, not a power of two.
module raster_cnt
  import life_ctrl_pkg::*;
#(
  parameter int N_PX = LIFE_N_PX,
  parameter int N_PY = LIFE_N_PY
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clr,
  input  logic                 i_adv,
  output logic [N_PX_BITS-1:0] o_x,
  output logic [N_PY_BITS-1:0] o_y,
  output logic                 o_last
);
  localparam logic [N_PX_BITS-1:0] X_MAX = N_PX_BITS'(N_PX - 1);
  localparam logic [N_PY_BITS-1:0] Y_MAX = N_PY_BITS'(N_PY - 1);

  logic [N_PX_BITS-1:0] r_x;
  logic [N_PY_BITS-1:0] r_y;
  logic                 w_x_wrap;
  logic                 w_y_wrap;

  assign w_x_wrap = (r_x == X_MAX);
  assign w_y_wrap = (r_y == Y_MAX);

  // Counter register: clear wins over advance.
  always_ff @(posedge clk) begin
    if (!reset || i_clr) begin
      r_x <= {N_PX_BITS{1'b0}};
      r_y <= {N_PY_BITS{1'b0}};
    end else if (i_adv) begin
      if (w_x_wrap) begin
        r_x <= {N_PX_BITS{1'b0}};
        r_y <= w_y_wrap ? {N_PY_BITS{1'b0}} : r_y + N_PY_BITS'(1);
      end else begin
        r_x <= r_x + N_PX_BITS'(1);
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = w_x_wrap && w_y_wrap;

endmodule

// File: rtl/life_seq_ctrl.sv
// Game-of-Life sequencer: raster pattern load, generation stepping with early
// stop on extinction, and raster readout over a valid/ready handshake.
module life_seq_ctrl
  import life_ctrl_pkg::*;
#(
  parameter int N_PX     = LIFE_N_PX,
  parameter int N_PY     = LIFE_N_PY,
  parameter int GEN_BITS = LIFE_GEN_BITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [PE_STATE_BITS-1:0] load_data,
  output logic                     load_ready,
  input  logic                     run_start,
  input  logic [GEN_BITS-1:0]      run_gens,
  input  logic                     read_start,
  output logic                     rd_valid,
  output logic [PE_STATE_BITS-1:0] rd_data,
  input  logic                     rd_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     extinct,
  output logic [GEN_BITS-1:0]      gens_done,
  output logic [PE_CMD_BITS-1:0]   cmd,
  output logic [PE_STATE_BITS-1:0] state_in,
  output logic [N_PX_BITS-1:0]     adr_x_i,
  output logic [N_PY_BITS-1:0]     adr_y_i,
  output logic [N_PX_BITS-1:0]     adr_x_o,
  output logic [N_PY_BITS-1:0]     adr_y_o,
  input  logic [PE_STATE_BITS-1:0] state_out,
  input  logic                     active
);
  localparam logic [GEN_BITS-1:0] GEN_ZERO = {GEN_BITS{1'b0}};
  localparam logic [GEN_BITS-1:0] GEN_ONE  = GEN_BITS'(1);
  localparam logic [GEN_BITS-1:0] GEN_MAX  = {GEN_BITS{1'b1}};

  seq_state_e               r_state;
  seq_state_e               w_nxt;
  logic [GEN_BITS-1:0]      r_rem;
  logic [GEN_BITS-1:0]      r_gens_done;
  logic                     r_extinct;
  logic                     r_rd_valid;
  logic [PE_STATE_BITS-1:0] r_rd_data;
  logic                     w_clr;
  logic                     w_adv;
  logic                     w_last;
  logic                     w_load_hs;
  logic                     w_run_go;
  logic [PE_CMD_BITS-1:0]   w_cmd;
  logic [N_PX_BITS-1:0]     w_x;
  logic [N_PY_BITS-1:0]     w_y;

  raster_cnt #(
    .N_PX (N_PX),
    .N_PY (N_PY)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_clr),
    .i_adv  (w_adv),
    .o_x    (w_x),
    .o_y    (w_y),
    .o_last (w_last)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  // Next-state, array command and counter control.
  always_comb begin
    w_nxt     = r_state;
    w_cmd     = PE_CMD_NOP;
    w_clr     = 1'b0;
    w_adv     = 1'b0;
    w_load_hs = 1'b0;
    w_run_go  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load_start) begin
          w_clr = 1'b1;
          w_nxt = ST_LOAD;
        end else if (run_start) begin
          w_clr    = 1'b1;
          w_run_go = 1'b1;
          w_nxt    = (run_gens == GEN_ZERO) ? ST_FIN : ST_STEP;
        end else if (read_start) begin
          w_clr = 1'b1;
          w_nxt = ST_RD_ADR;
        end else begin
          w_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (load_valid) begin
          w_load_hs = 1'b1;
          w_cmd     = PE_CMD_LOAD;
          w_adv     = 1'b1;
          w_nxt     = w_last ? ST_FIN : ST_LOAD;
        end else begin
          w_nxt = ST_LOAD;
        end
      end
      ST_STEP: begin
        w_cmd = PE_CMD_STEP;
        w_nxt = ST_SETTLE;
      end
      // active already reflects the generation just computed.
      ST_SETTLE: begin
        w_nxt = (!active || (r_rem == GEN_ONE)) ? ST_FIN : ST_STEP;
      end
      ST_RD_ADR: begin
        w_nxt = ST_RD_OUT;
      end
      ST_RD_OUT: begin
        if (rd_ready) begin
          w_adv = 1'b1;
          w_nxt = w_last ? ST_FIN : ST_RD_ADR;
        end else begin
          w_nxt = ST_RD_OUT;
        end
      end
      ST_FIN: begin
        w_nxt = ST_IDLE;
      end
      default: begin
        w_nxt = ST_IDLE;
      end
    endcase
  end

  // Run bookkeeping and readout data register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rem       <= GEN_ZERO;
      r_gens_done <= GEN_ZERO;
      r_extinct   <= 1'b0;
      r_rd_data   <= {PE_STATE_BITS{1'b0}};
      r_rd_valid  <= 1'b0;
    end else begin
      if (w_run_go) begin
        r_rem       <= run_gens;
        r_gens_done <= GEN_ZERO;
        r_extinct   <= 1'b0;
      end else if (r_state == ST_SETTLE) begin
        r_rem <= r_rem - GEN_ONE;
        if (r_gens_done != GEN_MAX) begin
          r_gens_done <= r_gens_done + GEN_ONE;
        end
        if (!active) begin
          r_extinct <= 1'b1;
        end
      end
      if (r_state == ST_RD_ADR) begin
        r_rd_data  <= state_out;
        r_rd_valid <= 1'b1;
      end else if ((r_state == ST_RD_OUT) && rd_ready) begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  assign cmd        = w_cmd;
  assign state_in   = w_load_hs ? load_data : {PE_STATE_BITS{1'b0}};
  assign adr_x_i    = w_x;
  assign adr_y_i    = w_y;
  assign adr_x_o    = w_x;
  assign adr_y_o    = w_y;
  assign load_ready = (r_state == ST_LOAD);
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_FIN);
  assign rd_valid   = r_rd_valid;
  assign rd_data    = r_rd_data;
  assign extinct    = r_extinct;
  assign gens_done  = r_gens_done;

endmodule

// File: tb/tb_life_seq_ctrl.sv
// Bench for life_seq_ctrl: a behavioural 8x8 Life array model plus
// randomized load/run/read operations checked against Life-rule expectations.
module tb_life_seq_ctrl;
  import life_ctrl_pkg::*;

  localparam int NX = 8;
  localparam int NY = 8;
  localparam int GB = 16;

  localparam logic [63:0] GLIDER   = (64'd1 << 1) | (64'd1 << 10) | (64'd1 << 16) | (64'd1 << 17) | (64'd1 << 18);
  localparam logic [63:0] BLINK_H  = (64'd1 << 26) | (64'd1 << 27) | (64'd1 << 28);
  localparam logic [63:0] BLINK_V  = (64'd1 << 19) | (64'd1 << 27) | (64'd1 << 35);
  localparam logic [63:0] SINGLE   = (64'd1 << 45);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     reset;
  logic                     load_start, load_valid, load_ready;
  logic [PE_STATE_BITS-1:0] load_data;
  logic                     run_start;
  logic [GB-1:0]            run_gens;
  logic                     read_start, rd_valid, rd_ready;
  logic [PE_STATE_BITS-1:0] rd_data;
  logic                     busy, done, extinct;
  logic [GB-1:0]            gens_done;
  logic [PE_CMD_BITS-1:0]   cmd;
  logic [PE_STATE_BITS-1:0] state_in, state_out;
  logic [N_PX_BITS-1:0]     adr_x_i, adr_x_o;
  logic [N_PY_BITS-1:0]     adr_y_i, adr_y_o;
  logic                     active;

  life_seq_ctrl #(.N_PX(NX), .N_PY(NY), .GEN_BITS(GB)) dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .run_start(run_start), .run_gens(run_gens), .read_start(read_start),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .busy(busy), .done(done), .extinct(extinct), .gens_done(gens_done),
    .cmd(cmd), .state_in(state_in),
    .adr_x_i(adr_x_i), .adr_y_i(adr_y_i), .adr_x_o(adr_x_o), .adr_y_o(adr_y_o),
    .state_out(state_out), .active(active)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] life_next(input logic [63:0] g);
    logic [63:0] r;
    int n;
    r = 64'd0;
    for (int y = 0; y < NY; y++) begin
      for (int x = 0; x < NX; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            if (!(dx == 0 && dy == 0) && (x + dx >= 0) && (x + dx < NX) && (y + dy >= 0) && (y + dy < NY))
              n += int'(g[(y + dy) * NX + x + dx]);
          end
        end
        r[y * NX + x] = (n == 3) || (g[y * NX + x] && (n == 2));
      end
    end
    return r;
  endfunction

  // Behavioural PE array: one bit per cell, dead cells beyond the border.
  logic [63:0] arr = 64'd0;
  int n_step = 0;
  int n_done = 0;
  int ld_x[$];
  int ld_y[$];
  int ld_d[$];
  logic [63:0] ref_grid = 64'd0;

  assign active    = |arr;
  assign state_out = arr[int'(adr_y_o) * NX + int'(adr_x_o)];

  always @(posedge clk) begin
    if (cmd == PE_CMD_LOAD) begin
      arr[int'(adr_y_i) * NX + int'(adr_x_i)] <= state_in;
      ld_x.push_back(int'(adr_x_i));
      ld_y.push_back(int'(adr_y_i));
      ld_d.push_back(int'(state_in));
    end else if (cmd == PE_CMD_STEP) begin
      arr    <= life_next(arr);
      n_step <= n_step + 1;
    end
    if (done) n_done <= n_done + 1;
  end

  task automatic chk_rst(input string tag);
    chk({tag, "_cmd"}, cmd, PE_CMD_NOP);
    chk({tag, "_adr"}, {adr_y_i, adr_x_i, adr_y_o, adr_x_o}, 64'd0);
    chk({tag, "_data"}, {state_in, rd_data}, 64'd0);
    chk({tag, "_gens"}, gens_done, 64'd0);
    chk({tag, "_flags"}, {load_ready, rd_valid, busy, done, extinct}, 64'd0);
  endtask

  task automatic post_done();
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    chk("idle_not_busy", busy, 1'b0);
  endtask

  task automatic load_op(input logic [63:0] pat, input int mode, input bit with_run);
    int hs, tmo, l0, s0, bad;
    logic [GB-1:0] g0;
    bit tog;
    l0 = ld_x.size(); s0 = n_step; g0 = gens_done;
    hs = 0; tmo = 0; bad = 0; tog = 1'b0;
    @(posedge clk); #1;
    load_start = 1'b1; run_start = with_run; run_gens = 16'd7;
    @(posedge clk); #1;
    load_start = 1'b0; run_start = 1'b0;
    while (hs < 64 && tmo < 2000) begin
      load_valid = (mode == 0) ? tog : ($urandom_range(0, 2) != 0);
      tog = ~tog;
      load_data = pat[hs];
      @(negedge clk);
      if (!load_ready || !busy) bad++;
      if (load_valid && load_ready) hs++;
      @(posedge clk); #1;
      tmo++;
    end
    load_valid = 1'b0;
    if (tmo >= 2000) chk("load_timeout", 64'd0, 64'd1);
    @(negedge clk);
    chk("load_done", done, 1'b1);
    chk("load_ready_busy", bad, 64'd0);
    chk("load_count", ld_x.size() - l0, 64'd64);
    bad = 0;
    for (int i = 0; i < 64 && (l0 + i) < ld_x.size(); i++) begin
      if (ld_x[l0 + i] != i % NX || ld_y[l0 + i] != i / NX || ld_d[l0 + i] != int'(pat[i])) bad++;
    end
    chk("load_raster", bad, 64'd0);
    chk("load_image", arr, pat);
    chk("load_no_step", n_step - s0, 64'd0);
    if (with_run) chk("load_run_ignored", gens_done, g0);
    ref_grid = pat;
    post_done();
  endtask

  task automatic run_op(input logic [GB-1:0] gens, input bit poke);
    logic [63:0] r;
    int g, cnt, s0, l0, bad;
    bit ext, seen;
    r = ref_grid; g = 0; ext = 1'b0;
    while (g < int'(gens)) begin
      r = life_next(r);
      g++;
      if (r == 64'd0) begin
        ext = 1'b1;
        break;
      end
    end
    s0 = n_step; l0 = ld_x.size(); bad = 0; seen = 1'b0;
    @(posedge clk); #1;
    run_start = 1'b1; run_gens = gens;
    @(posedge clk); #1;
    run_start = 1'b0; cnt = 1;
    while (!seen && cnt < 1000) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        if (!busy) bad++;
        @(posedge clk); #1;
        cnt++;
        if (poke && cnt == 3) begin
          load_start = 1'b1; read_start = 1'b1; run_start = 1'b1; run_gens = 16'd9;
        end else begin
          load_start = 1'b0; read_start = 1'b0; run_start = 1'b0;
        end
      end
    end
    load_start = 1'b0; read_start = 1'b0; run_start = 1'b0;
    chk("run_done_seen", seen, 1'b1);
    chk("run_cycles", cnt, 2 * g + 1);
    chk("run_gens_done", gens_done, g);
    chk("run_extinct", extinct, ext);
    chk("run_steps", n_step - s0, g);
    chk("run_no_load", ld_x.size() - l0, 64'd0);
    chk("run_busy", bad, 64'd0);
    chk("run_image", arr, r);
    ref_grid = r;
    post_done();
  endtask

  task automatic read_op(input logic [63:0] expv);
    int n, tmo, hold;
    bit stalled;
    logic [PE_STATE_BITS-1:0] pd;
    logic [N_PX_BITS-1:0] px;
    logic [N_PY_BITS-1:0] py;
    logic [63:0] got;
    n = 0; tmo = 0; hold = 0; stalled = 1'b0; got = 64'd0;
    pd = '0; px = '0; py = '0;
    @(posedge clk); #1;
    read_start = 1'b1; rd_ready = 1'b0;
    @(posedge clk); #1;
    read_start = 1'b0;
    while (n < 64 && tmo < 2000) begin
      @(negedge clk);
      if (!busy) chk("rd_busy", busy, 1'b1);
      if (stalled) begin
        chk("rd_hold_valid", rd_valid, 1'b1);
        chk("rd_hold_data", rd_data, pd);
        chk("rd_hold_adr", {adr_y_o, adr_x_o}, {py, px});
      end
      if (rd_valid) begin
        if (rd_ready) begin
          chk("rd_adr", {adr_y_o, adr_x_o}, {N_PY_BITS'(n / NX), N_PX_BITS'(n % NX)});
          got[n] = rd_data;
          n++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          pd = rd_data; px = adr_x_o; py = adr_y_o;
          if (n == 2) hold++;
        end
      end else stalled = 1'b0;
      @(posedge clk); #1;
      tmo++;
      rd_ready = (n == 2 && hold < 5) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
    rd_ready = 1'b0;
    if (tmo >= 2000) chk("rd_timeout", 64'd0, 64'd1);
    @(negedge clk);
    chk("rd_done", done, 1'b1);
    chk("rd_image", got, expv);
    post_done();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] pat;
    int s0, d0, tmo;
    reset = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_data = '0;
    run_start = 1'b0; run_gens = '0; read_start = 1'b0; rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_rst("rst");
    @(posedge clk); #1;
    reset = 1'b1;

    load_op(GLIDER, 0, 1'b1);
    read_op(GLIDER);

    load_op(BLINK_H, 1, 1'b0);
    run_op(16'd5, 1'b1);
    chk("blinker_vertical", ref_grid, BLINK_V);
    read_op(ref_grid);

    load_op(SINGLE, 1, 1'b0);
    run_op(16'd100, 1'b0);
    chk("single_gens", gens_done, 64'd1);
    chk("single_extinct", extinct, 1'b1);
    read_op(64'd0);

    run_op(16'd0, 1'b0);
    chk("zero_gens", gens_done, 64'd0);

    for (int k = 0; k < 3; k++) begin
      pat = {$urandom, $urandom};
      load_op(pat, 1, 1'b0);
      run_op(GB'($urandom_range(1, 30)), 1'b0);
      read_op(ref_grid);
    end

    // Reset in the middle of a run once three generations have completed.
    load_op(BLINK_H, 1, 1'b0);
    s0 = n_step; d0 = n_done; tmo = 0;
    @(posedge clk); #1;
    run_start = 1'b1; run_gens = 16'd20;
    @(posedge clk); #1;
    run_start = 1'b0;
    while (tmo < 100) begin
      @(negedge clk);
      if (gens_done == 16'd3) break;
      @(posedge clk); #1;
      tmo++;
    end
    chk("mid_reached_3", gens_done, 64'd3);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_rst("mid_rst");
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_no_done", n_done - d0, 64'd0);
    chk("mid_steps", n_step - s0, 64'd4);
    ref_grid = life_next(life_next(life_next(life_next(BLINK_H))));
    read_op(ref_grid);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
